// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter sharing one physical-memory port between the I-cache and D-cache.
// One transaction in flight: command is latched at grant, held until pmem_resp, then a one-cycle response.
module pmem_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [LINE_W-1:0] wdata_i,
    input  logic              mem_read_d,
    input  logic              mem_write_d,
    input  logic [ADDR_W-1:0] mem_addr_d,
    input  logic [LINE_W-1:0] wdata_d,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    output logic              mem_resp_i,
    output logic              mem_resp_d,
    output logic [LINE_W-1:0] inst_rdata,
    output logic [LINE_W-1:0] data_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_last_d;
    logic              r_grant_d;
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_addr;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic              r_resp_i;
    logic              r_resp_d;
    logic [LINE_W-1:0] r_inst_rdata;
    logic [LINE_W-1:0] r_data_rdata;

    logic              w_act_i;
    logic              w_act_d;
    logic              w_pick_d;
    logic              w_grant;
    logic              w_done;
    logic              w_sel_write;
    logic              w_sel_read;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LINE_W-1:0] w_sel_wdata;

    assign w_act_i = mem_read_i | mem_write_i;
    assign w_act_d = mem_read_d | mem_write_d;

    // D wins when it is the only requester, or on a tie when I was served last.
    assign w_pick_d = w_act_d & (~w_act_i | ~r_last_d);

    assign w_sel_write = w_pick_d ? mem_write_d : mem_write_i;
    assign w_sel_read  = w_pick_d ? mem_read_d  : mem_read_i;
    assign w_sel_addr  = w_pick_d ? mem_addr_d  : mem_addr_i;
    assign w_sel_wdata = w_pick_d ? wdata_d     : wdata_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_act_i | w_act_d) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (pmem_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d     <= 1'b1;
            r_grant_d    <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
            r_resp_i     <= 1'b0;
            r_resp_d     <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_resp_i <= 1'b0;
            r_resp_d <= 1'b0;
            if (w_grant) begin
                r_last_d     <= w_pick_d;
                r_grant_d    <= w_pick_d;
                r_pmem_write <= w_sel_write;
                r_pmem_read  <= w_sel_read & ~w_sel_write;
                r_pmem_addr  <= w_sel_addr;
                r_pmem_wdata <= w_sel_wdata;
            end
            if (w_done) begin
                r_pmem_read  <= 1'b0;
                r_pmem_write <= 1'b0;
                r_resp_i     <= ~r_grant_d;
                r_resp_d     <= r_grant_d;
                // Only reads refresh the returned line; write-backs leave it untouched.
                if (r_pmem_read) begin
                    if (r_grant_d) begin
                        r_data_rdata <= pmem_rdata;
                    end else begin
                        r_inst_rdata <= pmem_rdata;
                    end
                end
            end
        end
    end

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_pmem_addr;
    assign pmem_wdata = r_pmem_wdata;
    assign mem_resp_i = r_resp_i;
    assign mem_resp_d = r_resp_d;
    assign inst_rdata = r_inst_rdata;
    assign data_rdata = r_data_rdata;

endmodule
